// File: rtl/iot_sensor_pkg.sv
// iot_sensor_pkg: sensor IDs, framer state encoding and the packet checksum helper
// shared across the sensor packet path.
package iot_sensor_pkg;

    localparam logic [1:0] SID_NONE   = 2'b00;
    localparam logic [1:0] SID_TEMP   = 2'b01;
    localparam logic [1:0] SID_HUM    = 2'b10;
    localparam logic [1:0] SID_MOTION = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_POP, ST_CAPTURE, ST_SEND} framer_state_t;

    function automatic logic [7:0] pkt_checksum(input logic [255:0] v, input int nbytes);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 32; i++)
            if (i < nbytes) c = c ^ v[i*8 +: 8];
        return c;
    endfunction

endpackage

// File: rtl/sensor_packet_framer_checksum.sv
// pkt_checksum_calc: combinational byte-wise XOR over the packet body; a body that is
// not a whole number of bytes is zero-padded at the top.
module pkt_checksum_calc
    import iot_sensor_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] i_data,
    output logic [7:0]   o_csum
);

    localparam int NB = (W + 7) / 8;

    assign o_csum = pkt_checksum(256'(i_data), NB);

endmodule

// File: rtl/sensor_packet_framer.sv
// sensor_packet_framer: requests a sensor FIFO, pops the granted word and frames it into a
// checksummed packet on a valid/ready stream. FRAMER_TIMESTAMP_EN adds a capture timestamp.
module sensor_packet_framer
    import iot_sensor_pkg::*;
#(
    parameter int  DATA_W = 16,
    parameter int  SEQ_W  = 6,
    localparam int PKT_W  = 2 + SEQ_W + DATA_W + 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              temp_req,
    output logic              hum_req,
    output logic              motion_req,
    input  logic              temp_grant,
    input  logic              hum_grant,
    input  logic              motion_grant,
    input  logic              temp_fifo_empty,
    input  logic              hum_fifo_empty,
    input  logic              motion_fifo_empty,
    output logic              temp_rd_en,
    output logic              hum_rd_en,
    output logic              motion_rd_en,
    input  logic [DATA_W-1:0] temp_rd_data,
    input  logic [DATA_W-1:0] hum_rd_data,
    input  logic [DATA_W-1:0] motion_rd_data,
    output logic [PKT_W-1:0]  pkt_data,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic              busy,
    output logic              err_sticky,
    input  logic              err_clr
`ifdef FRAMER_TIMESTAMP_EN
    ,
    output logic [15:0]       pkt_ts
`endif
);

    framer_state_t      r_state;
    logic [1:0]         r_src;
    logic [SEQ_W-1:0]   r_seq;
    logic [PKT_W-1:0]   r_pkt;
    logic               r_err;

    logic               w_idle;
    logic               w_grant_any;
    logic               w_grant_multi;
    logic [1:0]         w_grant_id;
    logic               w_src_empty;
    logic [DATA_W-1:0]  w_rd_data;
    logic               w_pop;
    logic               w_err_set;
    logic [PKT_W-9:0]   w_body;
    logic [7:0]         w_csum;

    assign w_idle     = (r_state == ST_IDLE);
    assign temp_req   = w_idle & ~temp_fifo_empty;
    assign hum_req    = w_idle & ~hum_fifo_empty;
    assign motion_req = w_idle & ~motion_fifo_empty;

    // Simultaneous grants are an arbiter fault; resolve motion > temp > hum and flag it
    assign w_grant_any   = temp_grant | hum_grant | motion_grant;
    assign w_grant_multi = (temp_grant & hum_grant) | (temp_grant & motion_grant) | (hum_grant & motion_grant);
    assign w_grant_id    = motion_grant ? SID_MOTION : temp_grant ? SID_TEMP : hum_grant ? SID_HUM : SID_NONE;

    always_comb begin
        w_src_empty = (r_src == SID_TEMP) ? temp_fifo_empty :
                      (r_src == SID_HUM)  ? hum_fifo_empty  :
                      (r_src == SID_MOTION) ? motion_fifo_empty : 1'b1;
        w_rd_data   = (r_src == SID_TEMP) ? temp_rd_data :
                      (r_src == SID_HUM)  ? hum_rd_data  :
                      (r_src == SID_MOTION) ? motion_rd_data : '0;
    end

    assign w_pop        = (r_state == ST_POP) & ~w_src_empty;
    assign temp_rd_en   = w_pop & (r_src == SID_TEMP);
    assign hum_rd_en    = w_pop & (r_src == SID_HUM);
    assign motion_rd_en = w_pop & (r_src == SID_MOTION);
    assign w_err_set    = (w_idle & w_grant_multi) | ((r_state == ST_POP) & w_src_empty);
    assign w_body       = {r_src, r_seq, w_rd_data};

    pkt_checksum_calc #(.W(PKT_W - 8)) u_csum (
        .i_data (w_body),
        .o_csum (w_csum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_src   <= SID_NONE;
            r_seq   <= '0;
            r_pkt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= err_clr ? 1'b0 : (r_err | w_err_set);
            case (r_state)
                ST_IDLE: if (w_grant_any) begin
                    r_src   <= w_grant_id;
                    r_state <= ST_POP;
                end
                ST_POP: r_state <= w_src_empty ? ST_IDLE : ST_CAPTURE;
                ST_CAPTURE: begin
                    r_pkt   <= {w_body, w_csum};
                    r_state <= ST_SEND;
                end
                ST_SEND: if (pkt_ready) begin
                    r_seq   <= r_seq + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pkt_data   = r_pkt;
    assign pkt_valid  = (r_state == ST_SEND);
    assign busy       = ~w_idle;
    assign err_sticky = r_err;

`ifdef FRAMER_TIMESTAMP_EN
    logic [15:0] r_cyc;
    logic [15:0] r_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= '0;
            r_ts  <= '0;
        end else begin
            r_cyc <= r_cyc + 1'b1;
            if (r_state == ST_CAPTURE) r_ts <= r_cyc;
        end
    end

    assign pkt_ts = r_ts;
`endif

endmodule
